// File: rtl/vpu_ctrl_pkg.sv
// Shared control types for the vector/systolic control path: the writeback
// serializer state machine and the accumulator output mode used by decode.
package vpu_ctrl_pkg;

   // Writeback serializer states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } wb_state_t;

   // Accumulator output mode: full-width bytes or one saturated signed byte.
   typedef enum logic {
      FULL = 1'b0,
      SAT  = 1'b1
   } wb_mode_t;

endpackage

// File: rtl/acc_saturate.sv
// Purely combinational signed clamp of an accumulator value to one
// DATA_WIDTH-bit signed byte.
module acc_saturate #(
   parameter int ACC_WIDTH  = 32,
   parameter int DATA_WIDTH = 8
) (
   input  logic [ACC_WIDTH-1:0]  i_acc,
   output logic [DATA_WIDTH-1:0] o_sat
);

   // Clamp bounds sign-extended to the accumulator width.
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] w_acc_s;

   assign w_acc_s = $signed(i_acc);

   // Select the low byte unless the value lies outside the signed byte range.
   always_comb begin
      // NOTE: default assignment first so every path drives o_sat; no latch.
      o_sat = i_acc[DATA_WIDTH-1:0];
      if (w_acc_s < SAT_MIN) begin
         o_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else if (w_acc_s > SAT_MAX) begin
         o_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/acc_writeback_serializer.sv
// Drains the MATRIX_SIZE x MATRIX_SIZE accumulator bank into RAM port B one
// byte per granted cycle, either full width (little-endian) or saturated to
// one signed byte per element.
module acc_writeback_serializer
   import vpu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int MATRIX_SIZE    = 8,
   parameter int ACC_WIDTH      = 32,
   parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE),
   parameter int DP_ADDR_WIDTH  = 10,
   parameter int BYTES_PER_ACC  = ACC_WIDTH/DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DP_ADDR_WIDTH-1:0]  base_addr,
   input  logic                      sat_mode,
   output logic                      busy,
   output logic                      done,
   output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
   input  logic [ACC_WIDTH-1:0]      acc_out,
   input  logic                      ram_gnt,
   output logic                      we_b,
   output logic [DP_ADDR_WIDTH-1:0]  addr_b,
   output logic [DATA_WIDTH-1:0]     din_b
);

   localparam int BYTE_IDX_W = (BYTES_PER_ACC > 1) ? $clog2(BYTES_PER_ACC) : 1;

   localparam logic [BYTE_IDX_W-1:0]     LAST_BYTE = BYTE_IDX_W'(BYTES_PER_ACC-1);
   localparam logic [ACC_ADDR_WIDTH-1:0] LAST_ELEM = ACC_ADDR_WIDTH'(MATRIX_SIZE*MATRIX_SIZE-1);
   localparam logic [BYTE_IDX_W-1:0]     BYTE_ONE  = BYTE_IDX_W'(1);
   localparam logic [ACC_ADDR_WIDTH-1:0] ELEM_ONE  = ACC_ADDR_WIDTH'(1);
   localparam logic [DP_ADDR_WIDTH-1:0]  PTR_ONE   = DP_ADDR_WIDTH'(1);

   wb_state_t                                  r_state;
   wb_mode_t                                   r_mode;
   logic [DP_ADDR_WIDTH-1:0]                   r_wr_ptr;
   logic [ACC_ADDR_WIDTH-1:0]                  r_elem_idx;
   logic [BYTE_IDX_W-1:0]                      r_byte_idx;
   logic [BYTES_PER_ACC-1:0][DATA_WIDTH-1:0]   r_acc_q;
   // Last values presented on port B, held while not in WRITE.
   logic [DP_ADDR_WIDTH-1:0]                   r_addr_hold;
   logic [DATA_WIDTH-1:0]                      r_din_hold;

   logic [DATA_WIDTH-1:0]                      w_sat;
   logic [DATA_WIDTH-1:0]                      w_cur_byte;
   logic                                       w_last_byte;
   logic                                       w_in_write;

   acc_saturate #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_acc_saturate (
      .i_acc (acc_out),
      .o_sat (w_sat)
   );

   assign w_in_write  = (r_state == WRITE);
   assign w_cur_byte  = r_acc_q[r_byte_idx];
   // In saturate mode each element is exactly one byte, so byte 0 is last.
   assign w_last_byte = (r_mode == SAT) ? (r_byte_idx == '0)
                                        : (r_byte_idx == LAST_BYTE);

   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign addr_acc = r_elem_idx;
   assign we_b     = w_in_write && ram_gnt;
   assign addr_b   = w_in_write ? r_wr_ptr   : r_addr_hold;
   assign din_b    = w_in_write ? w_cur_byte : r_din_hold;

   // Serializer state machine: fetch, capture, then write one byte per grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_mode      <= FULL;
         r_wr_ptr    <= '0;
         r_elem_idx  <= '0;
         r_byte_idx  <= '0;
         r_acc_q     <= '0;
         r_addr_hold <= '0;
         r_din_hold  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_wr_ptr   <= base_addr;
                  r_mode     <= wb_mode_t'(sat_mode);
                  r_elem_idx <= '0;
                  r_byte_idx <= '0;
                  r_state    <= FETCH;
               end
            end
            FETCH: begin
               r_state <= CAPTURE;
            end
            CAPTURE: begin
               r_acc_q <= (r_mode == SAT) ? ACC_WIDTH'(w_sat) : acc_out;
               r_state <= WRITE;
            end
            WRITE: begin
               if (ram_gnt) begin
                  r_addr_hold <= r_wr_ptr;
                  r_din_hold  <= w_cur_byte;
                  r_wr_ptr    <= r_wr_ptr + PTR_ONE;
                  if (w_last_byte) begin
                     r_byte_idx <= '0;
                     if (r_elem_idx == LAST_ELEM) begin
                        r_state <= DONE;
                     end else begin
                        r_elem_idx <= r_elem_idx + ELEM_ONE;
                        r_state    <= FETCH;
                     end
                  end else begin
                     r_byte_idx <= r_byte_idx + BYTE_ONE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/acc_writeback_serializer.md
# acc_writeback_serializer

Drains the systolic array's MATRIX_SIZE×MATRIX_SIZE accumulator bank into the dual-port RAM, one byte per cycle. It is the write-side counterpart of the controller's LOAD path, which moves RAM bytes into the operand buffers. It implements the WRITE_ACC_OUT instruction: the controller pulses `start` with a RAM base address, waits for `done`, and then resumes fetching. The block owns RAM port B, gated by an arbiter grant.

## Interface

Parameters:

- DATA_WIDTH, 8, RAM byte width.
- MATRIX_SIZE, 8, array dimension; element count is MATRIX_SIZE².
- ACC_WIDTH, 32, accumulator width (signed); must be a multiple of DATA_WIDTH.
- ACC_ADDR_WIDTH, $clog2(MATRIX_SIZE*MATRIX_SIZE), accumulator index width.
- DP_ADDR_WIDTH, 10, RAM address width.
- BYTES_PER_ACC, ACC_WIDTH/DATA_WIDTH, bytes per element in full mode.

Ports:

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  DP_ADDR_WIDTH  first RAM byte address; captured with start.
- sat_mode  in  1  0 = full width (BYTES_PER_ACC bytes/element); 1 = saturate to one signed byte/element; captured with start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  out  1  one-cycle pulse on completion.
- addr_acc  out  ACC_ADDR_WIDTH  accumulator read index to systolic_module.
- acc_out  in  ACC_WIDTH  accumulator data; valid one cycle after addr_acc.
- ram_gnt  in  1  port-B grant; a write occurs only when high.
- we_b  out  1  RAM write enable.
- addr_b  out  DP_ADDR_WIDTH  RAM write address.
- din_b  out  DATA_WIDTH  RAM write data.

## Operation

- **States** are IDLE, FETCH, CAPTURE, WRITE and DONE.
- **IDLE:**
  - When start=1, capture base_addr into wr_ptr and sat_mode into mode_q.
  - Clear elem_idx and byte_idx, then go to FETCH.
  - start at any other time is ignored. No queuing.
- **FETCH:** drive addr_acc=elem_idx, then go to CAPTURE.
- **CAPTURE:** acc_q ← acc_out (full mode) or acc_q ← saturated value (sat mode), then go to WRITE.
- **Saturation:**
  - Signed compare against −2^(DATA_WIDTH−1) and 2^(DATA_WIDTH−1)−1.
  - Values below the minimum give 0x80; values above the maximum give 0x7F; otherwise the low DATA_WIDTH bits.
- **WRITE:**
  - we_b = ram_gnt, addr_b = wr_ptr, din_b = byte byte_idx of acc_q (little-endian: byte 0 = bits DATA_WIDTH−1:0).
  - On a granted cycle, wr_ptr and byte_idx increment.
  - With ram_gnt=0 all registers hold and we_b=0.
- **Last byte of an element** is byte_idx = BYTES_PER_ACC−1 in full mode, or byte 0 in sat mode.
  - After a granted write of the last byte, clear byte_idx.
  - If elem_idx = MATRIX_SIZE²−1, go to DONE; otherwise increment elem_idx and go to FETCH.
- **DONE:** done=1 for one cycle, then go to IDLE.
- **Address wrap:** wr_ptr wraps modulo 2^DP_ADDR_WIDTH with no error.
- **Element order:** row-major, index 0..MATRIX_SIZE²−1. The accumulator bank is read only; it is not cleared.
- **Reset:** rst mid-operation returns to IDLE immediately. Partial RAM contents are left as written.

## Timing

- **Reset values:** busy=0, done=0, we_b=0, addr_b=0, din_b=0, addr_acc=0. All internal registers are 0 and state is IDLE.
- **Output decode:** outputs are decoded combinationally from registered state. Outside WRITE, we_b=0 and addr_b/din_b hold their last values.
- **Full mode, ram_gnt always 1:**
  - Each element takes 2 + BYTES_PER_ACC cycles (6 with the defaults).
  - start accepted at cycle 0 → FETCH at cycle 1 → first write at cycle 3.
  - done at cycle 1 + MATRIX_SIZE²·(2+BYTES_PER_ACC) = 385 with the defaults.
- **Sat mode:** 3 cycles per element; done at cycle 193 with the defaults.
- **Grant stalls:** each ram_gnt=0 cycle in WRITE adds exactly one cycle. No bytes are dropped or duplicated.
- **start while busy:** ignored.
- **start in the DONE cycle:** ignored. start in the cycle after DONE (IDLE) is accepted.

## Structure

- **Shared package:** put the state enum `wb_state_t` and the `wb_mode_t` enum (FULL=0, SAT=1) in the shared package `vpu_ctrl_pkg`. The controller's instruction decode uses the mode enum too.
- **Sub-module:** `acc_saturate`, a purely combinational signed clamp parameterised by ACC_WIDTH and DATA_WIDTH, instantiated once in front of acc_q.
- **Counters:**
  - elem_idx is ACC_ADDR_WIDTH bits.
  - byte_idx is max(1, $clog2(BYTES_PER_ACC)) bits.
  - wr_ptr is DP_ADDR_WIDTH bits.

## Test plan

1. **Full-mode drain:** acc[i]=32'h0A0B0C00+i, base_addr=0, ram_gnt=1.
   - Bytes 0..3 are 00,0C,0B,0A.
   - Byte 255 is 0x0A.
   - done at cycle 385; busy falls the cycle after done.
2. **Sat-mode clamp:** acc[0]=300, acc[1]=−500, acc[2]=−5, acc[3]=127.
   - RAM[base..base+3] = 7F, 80, FB, 7F.
   - 64 writes total; done at cycle 193.
3. **Address wrap:** base_addr=0x3F0 in full mode.
   - Element 4 byte 0 lands at 0x000.
   - Last byte lands at 0x0EF.
4. **Grant stalls:** ram_gnt toggles 1,0,1,0 in full mode.
   - Byte sequence is identical to test 1.
   - we_b is never high while ram_gnt=0.
   - done is delayed by the number of stalled WRITE cycles.
5. **Ignored start:** pulse start with base_addr=0x200 at cycle 50 and in the DONE cycle.
   - No writes to 0x200.
   - A start one cycle after done is accepted.
6. **Reset mid-drain:** assert rst at cycle 100.
   - All outputs take reset values the same cycle.
   - A new start afterwards performs a full, correct drain.
